spi_adc_cmd_responder: RTL and testbench

- Responder end of the ADC command/response stream used by the synth's control-voltage inputs.
- Accepts Avalon-ST-style commands (valid/ready plus 5-bit channel) and runs one SPI conversion on an external 8-channel 12-bit MCP3208-class ADC.
- Returns a single-cycle response (valid, channel, 12-bit data).
- Lets the control path use off-chip inputs with the same command/response handshake as the on-chip modular ADC.

---
 rtl/spi_adc_cmd_responder_if.sv | 24 ++
 rtl/spi_adc_cmd_responder.sv | 210 +++++++++++++++++++++
 tb/tb_spi_adc_cmd_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_adc_cmd_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_adc_cmd_responder_if : command/response stream between the control   |
// | path (master) and the SPI ADC responder (slave).        Rev 1.0          |
// +--------------------------------------------------------------------------+
interface spi_adc_cmd_responder_if;
  logic        command_valid;
  logic [4:0]  command_channel;
  logic        command_ready;
  logic        response_valid;
  logic [4:0]  response_channel;
  logic [11:0] response_data;

  modport master (
    output command_valid, command_channel,
    input  command_ready, response_valid, response_channel, response_data
  );

  modport slave (
    input  command_valid, command_channel,
    output command_ready, response_valid, response_channel, response_data
  );
endinterface
`default_nettype wire

// File: rtl/spi_adc_cmd_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_adc_cmd_responder : runs one MCP3208 SPI conversion per command and  |
// | returns a one-cycle response. SPI_ADC_AVG_EN: average 4 frames. Rev 1.0  |
// +--------------------------------------------------------------------------+
module spi_adc_cmd_responder #(
  parameter int CLK_DIV = 25,
  parameter int CS_HOLD = 4
) (
  input  wire logic              MAX10_CLK1_50,
  input  wire logic              reset,
  spi_adc_cmd_responder_if.slave bus,
  output logic                   adc_cs_n,
  output logic                   adc_sclk,
  output logic                   adc_mosi,
  input  wire logic              adc_miso
);
  localparam int c_cnt_max = (CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(CLK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(CS_HOLD - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [4:0] c_last_period = 5'd18;
  localparam logic [4:0] c_first_data  = 5'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [4:0]          r_period;
  logic [4:0]          r_ch;
  logic [2:0]          r_adc_ch;
  logic                r_valid_ch;
  logic [11:0]         r_shift;
  logic                r_ready;
  logic                r_rvalid;
  logic [4:0]          r_rch;
  logic [11:0]         r_rdata;
  logic                r_cs_n;
  logic                r_sclk;
  logic                r_mosi;

  logic                w_accept;
  logic                w_in_range;
  logic [2:0]          w_adc_ch;

`ifdef SPI_ADC_AVG_EN
  logic [1:0]          r_frame;
  logic [13:0]         r_acc;
  logic [13:0]         w_sum;
  assign w_sum = r_acc + {2'b00, r_shift};
`endif

  // Header bits: start, single-ended, then D2..D0; the rest of the frame clocks zeros
  function automatic logic f_mosi_bit(input logic [4:0] period, input logic [2:0] ch);
    case (period)
      5'd0, 5'd1: f_mosi_bit = 1'b1;
      5'd2:       f_mosi_bit = ch[2];
      5'd3:       f_mosi_bit = ch[1];
      5'd4:       f_mosi_bit = ch[0];
      default:    f_mosi_bit = 1'b0;
    endcase
  endfunction

  assign w_accept   = bus.command_valid & r_ready;
  assign w_in_range = (bus.command_channel != 5'd0) && (bus.command_channel <= 5'd8);
  assign w_adc_ch   = bus.command_channel[2:0] - 3'd1;

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_period   <= '0;
      r_ch       <= '0;
      r_adc_ch   <= '0;
      r_valid_ch <= 1'b0;
      r_shift    <= '0;
      r_ready    <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rch      <= '0;
      r_rdata    <= '0;
      r_cs_n     <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
`ifdef SPI_ADC_AVG_EN
      r_frame    <= '0;
      r_acc      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready    <= 1'b0;
            r_ch       <= bus.command_channel;
            r_adc_ch   <= w_adc_ch;
            r_valid_ch <= w_in_range;
            if (w_in_range) begin
              r_state <= S_SETUP;
              r_cs_n  <= 1'b0;
              r_sclk  <= 1'b0;
              r_mosi  <= 1'b1;
              r_cnt   <= c_div_load;
`ifdef SPI_ADC_AVG_EN
              r_frame <= '0;
              r_acc   <= '0;
`endif
            end else begin
              r_state  <= S_DONE;
              r_rvalid <= 1'b1;
              r_rch    <= bus.command_channel;
              r_rdata  <= '0;
            end
          end
        end
        S_SETUP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_one;
          end else begin
            r_state  <= S_SHIFT;
            r_period <= '0;
            r_cnt    <= c_div_load;
            r_mosi   <= f_mosi_bit(5'd0, r_adc_ch);
          end
        end
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_one;
          end else if (!r_sclk) begin
            r_sclk <= 1'b1;
            r_cnt  <= c_div_load;
            if (r_period >= c_first_data)
              r_shift <= {r_shift[10:0], adc_miso};
          end else if (r_period != c_last_period) begin
            r_sclk   <= 1'b0;
            r_cnt    <= c_div_load;
            r_period <= r_period + 5'd1;
            r_mosi   <= f_mosi_bit(r_period + 5'd1, r_adc_ch);
          end else begin
            r_sclk <= 1'b0;
            r_cs_n <= 1'b1;
`ifdef SPI_ADC_AVG_EN
            if (r_frame == 2'd3) begin
              r_state  <= S_DONE;
              r_rvalid <= 1'b1;
              r_rch    <= r_ch;
              r_rdata  <= w_sum[13:2];
              r_frame  <= '0;
            end else begin
              r_state <= S_GAP;
              r_cnt   <= c_hold_load;
              r_acc   <= w_sum;
              r_frame <= r_frame + 2'd1;
            end
`else
            r_state  <= S_DONE;
            r_rvalid <= 1'b1;
            r_rch    <= r_ch;
            r_rdata  <= r_shift;
`endif
          end
        end
        S_DONE: begin
          r_rvalid <= 1'b0;
          if (r_valid_ch) begin
            r_state <= S_GAP;
            r_cnt   <= c_hold_load;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_one;
          end else
`ifdef SPI_ADC_AVG_EN
          if (r_frame != 2'd0) begin
            // more frames of the averaged command still to run
            r_state <= S_SETUP;
            r_cs_n  <= 1'b0;
            r_mosi  <= 1'b1;
            r_cnt   <= c_div_load;
          end else
`endif
          begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.command_ready    = r_ready;
  assign bus.response_valid   = r_rvalid;
  assign bus.response_channel = r_rch;
  assign bus.response_data    = r_rdata;
  assign adc_cs_n             = r_cs_n;
  assign adc_sclk             = r_sclk;
  assign adc_mosi             = r_mosi;
endmodule
`default_nettype wire

// File: tb/tb_spi_adc_cmd_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_adc_cmd_responder : directed bench with an ADC model and a        |
// | cycle-level behavioural reference for spi_adc_cmd_responder.  Rev 1.0   |
// +--------------------------------------------------------------------------+
module tb_spi_adc_cmd_responder;
  localparam int c_div   = 2;
  localparam int c_hold  = 4;
  localparam int c_frame = 39 * c_div;
`ifdef SPI_ADC_AVG_EN
  localparam int c_nf  = 4;
  localparam int c_lat = 325;
  localparam int c_rdy = 330;
`else
  localparam int c_nf  = 1;
  localparam int c_lat = 79;
  localparam int c_rdy = 84;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic adc_cs_n, adc_sclk, adc_mosi;
  logic adc_miso = 1'b0;

  spi_adc_cmd_responder_if bus();

  spi_adc_cmd_responder #(.CLK_DIV(c_div), .CS_HOLD(c_hold)) dut (
    .MAX10_CLK1_50 (clk),
    .reset         (reset),
    .bus           (bus),
    .adc_cs_n      (adc_cs_n),
    .adc_sclk      (adc_sclk),
    .adc_mosi      (adc_mosi),
    .adc_miso      (adc_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ADC model: MCP3208 replies B11..B0 in periods 7..18
  logic [11:0] adc_q[$];
  logic [11:0] cur_w = '0;
  int          rises = 0;
  int          last_rises = 0;
  logic [18:0] rx_mosi = '0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (reset) adc_q.delete();
    if (prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
      cur_w   = (adc_q.size() > 0) ? adc_q.pop_front() : 12'h000;
      rises   = 0;
      rx_mosi = '0;
    end
    if (adc_cs_n === 1'b0 && prev_sclk === 1'b0 && adc_sclk === 1'b1) begin
      rises++;
      rx_mosi = {rx_mosi[17:0], adc_mosi};
    end
    if (prev_cs === 1'b0 && adc_cs_n === 1'b1) last_rises = rises;
    adc_miso  = (adc_cs_n === 1'b0 && rises >= 7 && rises <= 18) ? cur_w[18 - rises] : 1'b0;
    prev_cs   = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  // ---------------- Reference model: expected timeline per accepted command
  typedef struct { int cyc; logic [4:0] ch; logic [11:0] dat; } resp_t;
  typedef struct { int s; int e; logic [2:0] c; } win_t;
  resp_t       q_resp[$];
  win_t        q_win[$];
  logic [11:0] exp_word_q[$];
  bit          m_en = 1'b0;
  int          m_rdy = 0;
  logic [4:0]  held_ch = '0;
  logic [11:0] held_dat = '0;

  function automatic logic exp_mosi(input int p, input logic [2:0] c);
    if (p <= 1) return 1'b1;
    if (p <= 4) return c[4 - p];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    int k, o, q, sum;
    logic ev;
    logic [4:0] ch;
    resp_t rr;
    win_t ww;
    k = cyc;
    if (m_en) begin
      chk("ready", bus.command_ready, k >= m_rdy);
      ev = 1'b0;
      while (q_resp.size() > 0 && q_resp[0].cyc < k) void'(q_resp.pop_front());
      if (q_resp.size() > 0 && q_resp[0].cyc == k) begin
        ev = 1'b1;
        held_ch  = q_resp[0].ch;
        held_dat = q_resp[0].dat;
        void'(q_resp.pop_front());
      end
      chk("resp_valid", bus.response_valid, ev);
      chk("resp_channel", bus.response_channel, held_ch);
      chk("resp_data", bus.response_data, held_dat);
      while (q_win.size() > 0 && q_win[0].e < k) void'(q_win.pop_front());
      if (q_win.size() > 0 && q_win[0].s <= k) begin
        o = k - q_win[0].s;
        chk("cs_n_frame", adc_cs_n, 0);
        if (o < c_div) begin
          chk("sclk_setup", adc_sclk, 0);
          chk("mosi_setup", adc_mosi, 1);
        end else begin
          q = o - c_div;
          chk("sclk_shift", adc_sclk, (q % (2 * c_div)) >= c_div);
          chk("mosi_shift", adc_mosi, exp_mosi(q / (2 * c_div), q_win[0].c));
        end
      end else begin
        chk("cs_n_idle", adc_cs_n, 1);
        chk("sclk_idle", adc_sclk, 0);
      end
    end
    if (reset) begin
      m_en  = 1'b1;
      m_rdy = k + 2;
      q_resp.delete();
      held_ch  = '0;
      held_dat = '0;
      for (int i = q_win.size() - 1; i >= 0; i--) begin
        if (q_win[i].s > k) q_win.delete(i);
        else if (q_win[i].e > k) q_win[i].e = k;
      end
    end else if (m_en && bus.command_valid === 1'b1 && k >= m_rdy) begin
      ch = bus.command_channel;
      if (ch >= 5'd1 && ch <= 5'd8) begin
        sum = 0;
        for (int f = 0; f < c_nf; f++) begin
          sum += (exp_word_q.size() > 0) ? int'(exp_word_q.pop_front()) : 0;
          ww.s = k + 1 + f * (c_frame + c_hold);
          ww.e = ww.s + c_frame - 1;
          ww.c = 3'(ch - 5'd1);
          q_win.push_back(ww);
        end
        rr.cyc = k + 1 + c_nf * c_frame + (c_nf - 1) * c_hold;
        rr.dat = 12'(sum / c_nf);
        m_rdy  = rr.cyc + 1 + c_hold;
      end else begin
        rr.cyc = k + 1;
        rr.dat = 12'h000;
        m_rdy  = k + 2;
      end
      rr.ch = ch;
      q_resp.push_back(rr);
    end
  end

  // ---------------- Response recorder for the directed checks
  int          rv_cyc[$];
  logic [4:0]  rv_ch[$];
  logic [11:0] rv_dat[$];
  always @(negedge clk) begin
    if (bus.response_valid === 1'b1) begin
      rv_cyc.push_back(cyc);
      rv_ch.push_back(bus.response_channel);
      rv_dat.push_back(bus.response_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rv();
    rv_cyc.delete();
    rv_ch.delete();
    rv_dat.delete();
  endtask

  task automatic push_n(input logic [11:0] w);
    for (int i = 0; i < c_nf; i++) begin
      adc_q.push_back(w);
      exp_word_q.push_back(w);
    end
  endtask

  task automatic wait_accept(output int t);
    t = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.command_ready === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout: got no command_ready, expected it within 3000 cycles");
    end
  endtask

  task automatic issue(input logic [4:0] ch, output int t);
    tick();
    bus.command_channel = ch;
    bus.command_valid   = 1'b1;
    wait_accept(t);
    tick();
    bus.command_valid   = 1'b0;
    bus.command_channel = 5'd7;
  endtask

  task automatic wait_ready(output int r);
    r = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.command_ready === 1'b1) begin
        r = cyc;
        break;
      end
    end
    if (r < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL ready_timeout: got no command_ready, expected it within 3000 cycles");
    end
  endtask

  task automatic run_cmd(input logic [4:0] ch, input int lat, input int rdy,
                         input logic [11:0] dat);
    int t, r;
    clear_rv();
    issue(ch, t);
    wait_ready(r);
    chk("resp_count", rv_cyc.size(), 1);
    if (rv_cyc.size() > 0) begin
      chk("resp_latency", rv_cyc[0] - t, lat);
      chk("resp_ch_literal", rv_ch[0], ch);
      chk("resp_data_literal", rv_dat[0], dat);
    end
    chk("ready_latency", r - t, rdy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, r;
    bus.command_valid   = 1'b0;
    bus.command_channel = 5'd0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_ready", bus.command_ready, 0);
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_sclk", adc_sclk, 0);
    chk("rst_mosi", adc_mosi, 0);
    chk("rst_rvalid", bus.response_valid, 0);
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("ready_after_reset", bus.command_ready, 1);

    push_n(12'hA5C);
    run_cmd(5'd1, c_lat, c_rdy, 12'hA5C);
    chk("ch1_mosi_header", rx_mosi[18:14], 5'b11000);
    chk("ch1_sclk_rises", last_rises, 19);

    push_n(12'hFFF);
    run_cmd(5'd8, c_lat, c_rdy, 12'hFFF);
    chk("ch8_mosi_header", rx_mosi[18:14], 5'b11111);
    chk("ch8_sclk_rises", last_rises, 19);

    run_cmd(5'd0, 1, 2, 12'h000);
    run_cmd(5'd9, 1, 2, 12'h000);
    run_cmd(5'd31, 1, 2, 12'h000);

    // command_valid held high across two frames
    push_n(12'h123);
    push_n(12'h456);
    clear_rv();
    tick();
    bus.command_channel = 5'd3;
    bus.command_valid   = 1'b1;
    wait_accept(t);
    while (cyc < t + c_rdy) tick();
    @(negedge clk);
    chk("btb_ready_again", bus.command_ready, 1);
    tick();
    bus.command_valid = 1'b0;
    wait_ready(r);
    chk("btb_resp_count", rv_cyc.size(), 2);
    if (rv_cyc.size() == 2) begin
      chk("btb_first_latency", rv_cyc[0] - t, c_lat);
      chk("btb_spacing", rv_cyc[1] - rv_cyc[0], c_rdy);
      chk("btb_data0", rv_dat[0], 12'h123);
      chk("btb_data1", rv_dat[1], 12'h456);
      chk("btb_ch1", rv_ch[1], 5'd3);
    end

    // reset pulse during SHIFT period 10 of the first frame
    push_n(12'h5A5);
    clear_rv();
    issue(5'd4, t);
    while (cyc < t + 44) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_cs_n", adc_cs_n, 1);
    chk("abort_sclk", adc_sclk, 0);
    repeat (120) tick();
    chk("abort_no_response", rv_cyc.size(), 0);
    push_n(12'h3C7);
    run_cmd(5'd2, c_lat, c_rdy, 12'h3C7);

`ifdef SPI_ADC_AVG_EN
    adc_q.push_back(12'h100); exp_word_q.push_back(12'h100);
    adc_q.push_back(12'h101); exp_word_q.push_back(12'h101);
    adc_q.push_back(12'h102); exp_word_q.push_back(12'h102);
    adc_q.push_back(12'h103); exp_word_q.push_back(12'h103);
    run_cmd(5'd5, 325, 330, 12'h101);
`endif

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
